// File: rtl/uart_tx_frame.sv
// UART transmitter: one DATA_W-bit word per request, LSB first, start bit, optional parity,
// one or two stop bits, eight runtime baud rates. Parity support is compiled in by UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              send_en,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              t_data,
  output logic              tx_done,
  output logic              uart_state
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // Handshake: a request is taken only when send_en is high in a cycle where uart_state
  // is low; there is no ready/queue, so requests during a frame are simply dropped.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q;
  logic [DIV_W-1:0]  period_q;
  logic              stop2_q;
  logic              t_data_d, tx_done_d, uart_state_d;
  logic              last;

  function automatic logic [DIV_W-1:0] period_of(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0: baud = 9600;
      3'd1: baud = 19200;
      3'd2: baud = 38400;
      3'd3: baud = 57600;
      3'd4: baud = 115200;
      3'd5: baud = 230400;
      3'd6: baud = 460800;
      3'd7: baud = 921600;
    endcase
    return DIV_W'(CLK_HZ / baud);
  endfunction

`ifdef UART_TX_PARITY_EN
  logic [1:0] pmode_q;
  logic       par_on;
  logic       par_bit;
  assign par_on  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_bit = (^data_q) ^ (pmode_q == 2'b01);
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  assign last = (cnt_q == period_q - DIV_W'(1));

  // State register plus captured frame settings and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      period_q   <= '0;
      stop2_q    <= 1'b0;
      t_data     <= 1'b1;
      tx_done    <= 1'b0;
      uart_state <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pmode_q    <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      t_data     <= t_data_d;
      tx_done    <= tx_done_d;
      uart_state <= uart_state_d;
      if (state_q == S_IDLE && send_en) begin
        data_q   <= data;
        period_q <= period_of(baud_set);
        stop2_q  <= stop2;
`ifdef UART_TX_PARITY_EN
        pmode_q  <= parity_mode;
`endif
      end
    end
  end

  // Next state, bit-period counter and bit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + DIV_W'(1);
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (send_en) state_d = S_START;
      end
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (last) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_on ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
`endif
      S_STOP: begin
        // idx counts stop bits; the frame ends after the first or second one.
        if (last) begin
          if (idx_q[0] == stop2_q) state_d = S_IDLE;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are computed for the coming cycle and registered, so they never glitch.
  always_comb begin
    t_data_d = 1'b1;
    case (state_d)
      S_START:  t_data_d = 1'b0;
      S_DATA:   t_data_d = data_q[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: t_data_d = par_bit;
`endif
      default:  t_data_d = 1'b1;
    endcase
    uart_state_d = (state_d != S_IDLE);
    tx_done_d    = (state_q == S_STOP) && (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle frame model with expected queue plus literal frame checks.
// Covers both builds of UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       send_en = 1'b0;
  logic [2:0] baud_set = '0;
  logic [1:0] parity_mode = '0;
  logic       stop2 = 1'b0;
  logic       t_data, tx_done, uart_state;

  int checks = 0;
  int errors = 0;

  // expected {t_data, uart_state, tx_done} for each upcoming cycle
  logic [2:0] exp_q[$];
  bit         chk_en = 1'b0;

  int mon_cyc = 0, run_cnt = 0, last_run = 0;
  int done_count = 0, done_prev = 0, done_last = 0;

  uart_tx_frame #(.CLK_HZ(50_000_000), .DATA_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .data(data), .send_en(send_en), .baud_set(baud_set),
    .parity_mode(parity_mode), .stop2(stop2), .t_data(t_data), .tx_done(tx_done),
    .uart_state(uart_state)
  );

  always #5 clk = ~clk;

  function automatic int period_tb(input logic [2:0] b);
    case (b)
      3'd0: return 5208;
      3'd1: return 2604;
      3'd2: return 1302;
      3'd3: return 868;
      3'd4: return 434;
      3'd5: return 217;
      3'd6: return 108;
      default: return 54;
    endcase
  endfunction

  task automatic build_frame(input logic [7:0] d, input logic [2:0] b, input logic [1:0] pm,
                             input logic s2);
    logic bits[$];
    int p;
    p = period_tb(b);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (pm == 2'b01) bits.push_back(~(^d));
    if (pm == 2'b10) bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < p; c++) exp_q.push_back({bits[i], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
  endtask

  // Model and compare: one check of all outputs per cycle after the first reset.
  always @(negedge clk) begin
    logic [2:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
    if (chk_en) begin
      checks++;
      if ({t_data, uart_state, tx_done} !== e) begin
        errors++;
        $display("FAIL line_cycle t=%0t got t_data/uart_state/tx_done=%b expected=%b",
                 $time, {t_data, uart_state, tx_done}, e);
      end
    end
    if (rst) begin
      exp_q.delete();
      chk_en = 1'b1;
    end else if (send_en && !e[1]) begin
      build_frame(data, baud_set, parity_mode, stop2);
    end
  end

  always @(negedge clk) begin
    mon_cyc++;
    if (uart_state === 1'b1) run_cnt++;
    else begin
      if (run_cnt != 0) last_run = run_cnt;
      run_cnt = 0;
    end
    if (tx_done === 1'b1) begin
      done_count++;
      done_prev = done_last;
      done_last = mon_cyc;
    end
  end

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] b, input logic [1:0] pm,
                      input logic s2);
    @(posedge clk); #1;
    data = d; baud_set = b; parity_mode = pm; stop2 = s2; send_en = 1'b1;
    @(posedge clk); #1;
    send_en = 1'b0;
    data = 8'($urandom);
    baud_set = 3'($urandom_range(0, 7));
    parity_mode = 2'($urandom_range(0, 3));
    stop2 = 1'($urandom_range(0, 1));
  endtask

  task automatic sample_bits(input int p, input int n, output logic [11:0] s);
    s = '1;
    repeat (p / 2) @(posedge clk);
    #1 s[0] = t_data;
    for (int i = 1; i < n; i++) begin
      repeat (p) @(posedge clk);
      #1 s[i] = t_data;
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done got=timeout expected=tx_done within %0d cycles", budget);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [11:0] s;
    int dc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", {t_data, uart_state, tx_done}, 3'b100);

    // 8N1 0xAA at 115200
    send(8'hAA, 3'd4, 2'b00, 1'b0);
    sample_bits(434, 10, s);
    check("aa_bits", s[9:0], 10'b1101010100);
    wait_done(1000);
    settle();
    check("aa_busy_len", last_run, 4340);
    check("aa_done_count", done_count, 1);

`ifdef UART_TX_PARITY_EN
    send(8'h55, 3'd4, 2'b10, 1'b0);
    sample_bits(434, 11, s);
    check("even_data", s[8:1], 8'h55);
    check("even_parity", s[9], 0);
    wait_done(1000);
    settle();
    check("even_busy_len", last_run, 4774);

    send(8'h55, 3'd4, 2'b01, 1'b0);
    sample_bits(434, 11, s);
    check("odd_parity", s[9], 1);
    wait_done(1000);
    settle();
    check("odd_busy_len", last_run, 4774);

    send(8'h55, 3'd4, 2'b10, 1'b1);
    sample_bits(434, 12, s);
    check("stop2_parity", s[9], 0);
    check("stop2_stop_bits", s[11:10], 2'b11);
    wait_done(1000);
    settle();
    check("stop2_busy_len", last_run, 5208);
`else
    send(8'hAA, 3'd4, 2'b10, 1'b0);
    sample_bits(434, 10, s);
    check("noparity_bits", s[9:0], 10'b1101010100);
    wait_done(1000);
    settle();
    check("noparity_busy_len", last_run, 4340);
`endif

    // request in the middle of a frame is dropped
    dc = done_count;
    send(8'hAA, 3'd4, 2'b00, 1'b0);
    repeat (2000) @(posedge clk);
    #1 data = 8'h0F; send_en = 1'b1;
    @(posedge clk); #1 send_en = 1'b0;
    wait_done(3000);
    settle();
    repeat (3000) @(posedge clk);
    #1;
    check("midframe_done_count", done_count - dc, 1);
    check("midframe_busy_len", last_run, 4340);

    // back-to-back at 921600: new request in the tx_done cycle
    send(8'hAA, 3'd7, 2'b00, 1'b0);
    wait_done(700);
    data = 8'h55; baud_set = 3'd7; parity_mode = 2'b00; stop2 = 1'b0; send_en = 1'b1;
    @(posedge clk); #1 send_en = 1'b0;
    check("b2b_start_bit", {t_data, uart_state}, 2'b01);
    wait_done(700);
    settle();
    check("b2b_gap", done_last - done_prev - 1, 540);
    check("b2b_busy_len", last_run, 540);

    // reset during data bit 3 aborts the frame
    send(8'hAA, 3'd4, 2'b00, 1'b0);
    repeat (4 * 434 + 100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_outputs", {t_data, uart_state, tx_done}, 3'b100);
    dc = done_count;
    repeat (3000) @(posedge clk);
    #1;
    check("abort_no_done", done_count - dc, 0);

    send(8'h3C, 3'd6, 2'b00, 1'b0);
    sample_bits(108, 10, s);
    check("after_reset_bits", s[9:0], 10'b1001111000);
    wait_done(300);
    settle();
    check("after_reset_busy_len", last_run, 1080);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
